// File: rtl/acpi_pwr_btn_decoder.sv
// ACPI power button receiver: synchronises and debounces PWRBTN#, classifies
// each press as short or long, tracks S0/S5 and raises pulses plus sticky
// status for the PMS firmware and power sequencer.
module acpi_pwr_btn_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_CYC   = 1000,
    parameter int LONG_PRESS_CYC = 400000,
    parameter int CNT_W          = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       pwr_btn_ni,
    input  logic [1:0] evt_clr_i,
    output logic       btn_pressed_o,
    output logic       pwr_on_req_o,
    output logic       pwr_off_req_o,
    output logic       forced_off_o,
    output logic       s0_o,
    output logic [1:0] evt_status_o,
    output logic       irq_o
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYC - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic                   btn_db;
    logic                   btn_db_q;
    logic                   db_rise;
    logic [CNT_W-1:0]       db_cnt;
    logic [CNT_W-1:0]       press_cnt;
    logic [CNT_W-1:0]       press_cnt_nxt;
    state_t                 state;
    state_t                 state_nxt;
    logic                   short_evt;
    logic                   long_evt;

    // Pin synchroniser; flops idle at 1 so reset looks like a released button.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pwr_btn_ni};
    end

    assign btn_sync = ~sync_q[SYNC_STAGES-1];

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_sync != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= btn_sync;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Only a fresh debounced rise starts a press, so a press already held when en_i rises is ignored.
    assign db_rise = btn_db & ~btn_db_q;

    // Press FSM state and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            press_cnt <= '0;
        end else begin
            state     <= state_nxt;
            press_cnt <= press_cnt_nxt;
        end
    end

    // Press classification; reaching the long threshold beats a same-cycle release.
    always_comb begin
        state_nxt     = state;
        press_cnt_nxt = press_cnt;
        short_evt     = 1'b0;
        long_evt      = 1'b0;
        case (state)
            IDLE: begin
                if (en_i && db_rise) begin
                    state_nxt     = PRESSED;
                    press_cnt_nxt = '0;
                end
            end
            PRESSED: begin
                if (!en_i) begin
                    state_nxt = IDLE;
                end else if (press_cnt == LONG_LAST) begin
                    long_evt  = 1'b1;
                    state_nxt = HELD;
                end else if (!btn_db) begin
                    short_evt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    press_cnt_nxt = press_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!en_i || !btn_db) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered event pulses, sleep state and sticky status (a set beats a same-cycle clear).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwr_on_req_o  <= 1'b0;
            pwr_off_req_o <= 1'b0;
            forced_off_o  <= 1'b0;
            s0_o          <= 1'b0;
            evt_status_o  <= 2'b00;
        end else begin
            pwr_on_req_o  <= short_evt & ~s0_o;
            pwr_off_req_o <= short_evt & s0_o;
            forced_off_o  <= long_evt & s0_o;
            if (short_evt && !s0_o)     s0_o <= 1'b1;
            else if (long_evt && s0_o)  s0_o <= 1'b0;
            evt_status_o <= (evt_status_o & ~evt_clr_i) | {long_evt, short_evt};
        end
    end

    assign btn_pressed_o = btn_db;
    assign irq_o         = |evt_status_o;

endmodule

// File: tb/tb_acpi_pwr_btn_decoder.sv
// Bench for acpi_pwr_btn_decoder: press-level reference model feeds an
// expected-pulse queue; an independent monitor pops and checks each pulse.
module tb_acpi_pwr_btn_decoder;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       pin;
    logic [1:0] clr;
    logic       btn_pressed, on_req, off_req, forced, s0, irq;
    logic [1:0] status;

    acpi_pwr_btn_decoder #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB), .LONG_PRESS_CYC(LONG), .CNT_W(32)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pwr_btn_ni(pin), .evt_clr_i(clr),
        .btn_pressed_o(btn_pressed), .pwr_on_req_o(on_req), .pwr_off_req_o(off_req),
        .forced_off_o(forced), .s0_o(s0), .evt_status_o(status), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // kind: 0 = power-on, 1 = graceful-off, 2 = forced-off
    typedef struct {int kind; int at;} exp_t;
    exp_t q[$];

    bit         exp_s0;
    logic [1:0] exp_st;

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the expected queue.
    exp_t mon_e;
    int   mon_kind;
    always @(negedge clk) begin
        if (on_req || off_req || forced) begin
            if ($countones({on_req, off_req, forced}) > 1) mon_kind = 9;
            else if (on_req)  mon_kind = 0;
            else if (off_req) mon_kind = 1;
            else              mon_kind = 2;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got kind %0d at cyc %0d, want no pulse", mon_kind, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("pulse_kind", mon_kind, mon_e.kind);
                chk("pulse_time", cyc, mon_e.at);
                chk("status_at_pulse", int'(status[(mon_e.kind == 2) ? 1 : 0]), 1);
            end
        end
    end

    task automatic check_state(string tag);
        chk({tag, "_s0"}, int'(s0), int'(exp_s0));
        chk({tag, "_status"}, int'(status), int'(exp_st));
        chk({tag, "_irq"}, int'(irq), int'(|exp_st));
    endtask

    // One pin-low pulse of len cycles followed by an idle gap.
    task automatic press(int len, bit en_start, int en_rise_at, bit hold_clr);
        int  c0, first, hi;
        @(negedge clk);
        en = en_start;
        if (hold_clr) clr = 2'b11;
        @(negedge clk);
        pin = 1'b0;
        c0  = cyc;
        // reference: a press exists iff it outlasts the debounce window
        if (len >= DEB && en_start) begin
            if (len < LONG) begin
                exp_st[0] = 1'b1;
                if (!exp_s0) begin
                    q.push_back('{0, c0 + SYNC + DEB + 1 + len});
                    exp_s0 = 1'b1;
                end else begin
                    q.push_back('{1, c0 + SYNC + DEB + 1 + len});
                end
            end else begin
                exp_st[1] = 1'b1;
                if (exp_s0) begin
                    q.push_back('{2, c0 + SYNC + DEB + 1 + LONG});
                    exp_s0 = 1'b0;
                end
            end
        end
        first = -1;
        hi    = 0;
        for (int i = 1; i <= len + 14; i++) begin
            @(negedge clk);
            if (btn_pressed) begin
                hi++;
                if (first < 0) first = cyc - c0;
            end
            if (i == len) pin = 1'b1;
            if (i == en_rise_at) en = 1'b1;
        end
        if (hold_clr) begin
            clr    = 2'b00;
            exp_st = 2'b00;
        end
        chk("db_high_cycles", hi, (len >= DEB) ? len : 0);
        if (len >= DEB) chk("db_latency", first, SYNC + DEB);
        @(negedge clk);
        check_state("after_press");
    endtask

    task automatic clear_status(logic [1:0] mask);
        @(negedge clk);
        clr = mask;
        @(negedge clk);
        clr = 2'b00;
        exp_st = exp_st & ~mask;
        chk("status_after_clr", int'(status), int'(exp_st));
    endtask

    initial begin
        int len;
        rst = 1'b1; en = 1'b1; pin = 1'b1; clr = 2'b00;
        exp_s0 = 1'b0; exp_st = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pressed", int'(btn_pressed), 0);
        chk("rst_pulses", int'({on_req, off_req, forced}), 0);
        check_state("rst");

        press(10, 1'b1, -1, 1'b0);   // short in S5 -> power on
        press(40, 1'b1, -1, 1'b0);   // long in S0 -> forced off
        press(3,  1'b1, -1, 1'b0);   // glitch rejected
        press(DEB, 1'b1, -1, 1'b0);  // shortest accepted press -> power on
        clear_status(2'b11);
        press(10, 1'b1, -1, 1'b1);   // graceful off with clear held across the event
        press(LONG - 1, 1'b1, -1, 1'b0); // longest short press
        press(40, 1'b0, -1, 1'b0);   // disabled: ignored
        press(30, 1'b0, 15, 1'b0);   // enabled mid-press: ignored

        // reset in the middle of a disabled press while in S0
        @(negedge clk);
        en = 1'b0;
        pin = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_s0 = 1'b0;
        exp_st = 2'b00;
        chk("midrst_pulses", int'({on_req, off_req, forced}), 0);
        chk("midrst_pressed", int'(btn_pressed), 0);
        check_state("midrst");
        repeat (10) @(negedge clk);
        pin = 1'b1;
        repeat (15) @(negedge clk);
        check_state("midrst_release");

        press(LONG, 1'b1, -1, 1'b0); // long in S5: status only
        press(10, 1'b1, -1, 1'b0);   // power on again

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 9))
                0, 1:       len = $urandom_range(1, DEB - 1);
                2, 3, 4, 5: len = $urandom_range(DEB, LONG - 1);
                default:    len = $urandom_range(LONG, 45);
            endcase
            press(len, ($urandom_range(0, 3) != 0), -1, 1'b0);
            if ($urandom_range(0, 4) == 0) clear_status(2'($urandom_range(1, 3)));
        end

        repeat (20) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
